qtable_writer: RTL
==================

# qtable_writer

Write-back engine for the Q-learning neighbour table held in `mem`, the opposite direction of the reward unit's table reads. When the reward stage finishes, `qtable_writer` takes one updated neighbour record (node ID, cluster ID, new Q-value, hop count) and writes it as four consecutive 16-bit words into the record slot selected by the neighbour index. It drives the memory's `address` / `wr_en` / `mem_data_in` port and answers with a level-held `done`, matching the `done_prev` / `done_reward` chaining used between stages.

## Interface
- `TABLE_BASE`, 16'h0100, byte address of neighbour record 0.
- `MAX_NEIGHBORS`, 32, number of record slots; valid `nbr_index` is 0..MAX_NEIGHBORS-1.
- `RECORD_BYTES`, 8, slot stride: 4 words × 2 bytes.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request from the reward stage (its `done_reward`).
- `nbr_index`  in  8  target slot.
- `node_id`, `cluster_id`, `q_value`, `hop_count`  in  16 each  record words 0..3.
- `address`  out  16  memory byte address.
- `wr_en`  out  1  memory write strobe.
- `mem_data_in`  out  16  write data to memory.
- `mem_data_out`  in  16  memory read data (synchronous, 1-cycle latency).
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  completion level, held until `start` falls.
- `range_err`  out  1  `nbr_index` was out of range; no write performed.
- `verify_err`  out  1  read-back mismatch (only with `QW_READBACK_EN`).

## Operation
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE: when `start` = 1, latch `nbr_index` and all four record words, and set `busy` = 1.
  - If `nbr_index` ≥ MAX_NEIGHBORS, go straight to DONE with `range_err` = 1.
  - Otherwise go to WRITE with word counter k = 0.
- WRITE: drive `address` = TABLE_BASE + nbr_index·RECORD_BYTES + 2k (modulo 2^16, silent wrap), `wr_en` = 1, and `mem_data_in` = word k.
  - Increment k each cycle.
  - After k = 3, go to VERIFY if readback is compiled in, else DONE.
- VERIFY: issue reads k = 0..3 on consecutive cycles with `wr_en` = 0. Compare `mem_data_out` one cycle after each address against latched word k. Any mismatch sets sticky `verify_err`. Go to DONE after the 4th compare.
- DONE: `done` = 1, `busy` = 0. Return to IDLE when `start` = 0, clearing `done`.
  - `range_err` and `verify_err` stay valid until the next accepted start, which clears them.
- Inputs are ignored except in IDLE. Changes to the record inputs mid-operation have no effect.
- `start` still high on return to IDLE is impossible, because DONE waits for its fall. No double-write occurs.
- Outside WRITE, `wr_en` = 0, `mem_data_in` holds its last value, and `address` = 0 in IDLE.

## Timing
- Reset values: `address` = 0, `wr_en` = 0, `mem_data_in` = 0, `busy` = 0, `done` = 0, `range_err` = 0, `verify_err` = 0. State is IDLE.
- Start sampled high at edge 0 → `wr_en` high during cycles 1–4, carrying words 0..3.
- Without readback: `done` rises at edge 5.
- With readback: read addresses on cycles 5–8, compares on cycles 6–9, `done` rises at edge 10.
- Range error: `done` rises at edge 1, with no `wr_en` pulse.
- `nreset` asserted mid-operation: all outputs go to reset values immediately. Words already written stay in memory; no rollback.

## Configuration
- `QW_READBACK_EN` defined: the VERIFY state and `verify_err` logic are compiled in.
- `QW_READBACK_EN` undefined:
  - VERIFY is absent.
  - `verify_err` is tied to 0.
  - `mem_data_out` is unused.

## Structure
- Shared constants go in the common defines header: WORD_WIDTH (16), MEM_DEPTH, the record word offsets (NODE = 0, CLUSTER = 1, QVAL = 2, HOP = 3), and the state encodings.
- One sub-module, `qtable_addr_gen`: combinational slot/word-to-byte-address computation, shared with the reward unit's read side.

## Test plan
- Default parameters, nbr_index = 2, node_id = 2, cluster_id = 3, q_value = 16'h0050, hop_count = 6 → writes to 0x0110, 0x0112, 0x0114, 0x0116 with those values. `done` at edge 5; memory readback matches.
- nbr_index = 32 → no `wr_en`, `range_err` = 1, `done` at edge 1.
- Hold `start` high for 20 cycles after `done` → exactly four writes. Drop `start` → `done` clears, `busy` = 0.
- Pulse `nreset` low after the second write → outputs reset at once. Memory shows words 0–1 updated and words 2–3 unchanged. A subsequent start completes normally.
- With `QW_READBACK_EN` and a bench that corrupts the word at address 0x0114 → `verify_err` = 1 at `done` (edge 10); clears on the next start.
- TABLE_BASE = 16'hFFFC, nbr_index = 0 → addresses 0xFFFC, 0xFFFE, 0x0000, 0x0002 (wrap).

Source files
------------

// File: rtl/qtable_writer_pkg.sv
// qtable_writer_pkg
//   Shared constants for the Q-table write-back path: word width, memory
//   depth in words, the word offsets inside a neighbour record and the
//   writer FSM state encoding. Imported by qtable_addr_gen and qtable_writer.
package qtable_writer_pkg;

    localparam int WORD_WIDTH       = 16;
    localparam int MEM_DEPTH        = 32768;  // 64 KiB byte space, 16-bit words
    localparam int WORDS_PER_RECORD = 4;

    // Word offsets inside one neighbour record
    localparam int W_NODE    = 0;
    localparam int W_CLUSTER = 1;
    localparam int W_QVAL    = 2;
    localparam int W_HOP     = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/qtable_addr_gen.sv
// qtable_addr_gen
//   Combinational slot/word to byte-address mapping for the neighbour table,
//   shared by the reward unit's read side and the write-back engine.
//   addr = TABLE_BASE + slot*RECORD_BYTES + 2*word, wrapping modulo 2^16.
// Ports:
//   slot  in  8   record slot index
//   word  in  2   word index inside the record
//   addr  out 16  byte address
module qtable_addr_gen
    import qtable_writer_pkg::*;
#(
    parameter logic [15:0] TABLE_BASE   = 16'h0100,
    parameter int          RECORD_BYTES = 8
) (
    input  logic [7:0]            slot,
    input  logic [1:0]            word,
    output logic [WORD_WIDTH-1:0] addr
);

    // All terms are 16 bits wide, so the sum wraps silently at 2^16.
    assign addr = TABLE_BASE
                + 16'(slot) * 16'(RECORD_BYTES)
                + {13'd0, word, 1'b0};

endmodule

// File: rtl/qtable_writer.sv
// qtable_writer
//   Write-back engine for the Q-learning neighbour table. On an accepted
//   start it latches one neighbour record and writes it as four consecutive
//   16-bit words into the slot selected by nbr_index, then holds done until
//   start falls. Out-of-range slots are rejected with range_err and no write.
//   Optional build macro QW_READBACK_EN adds a VERIFY pass that reads the
//   four words back and flags any mismatch on verify_err.
// Ports:
//   clock, nreset                 clock, asynchronous active-low reset
//   start                         level request from the reward stage
//   nbr_index                     target record slot
//   node_id/cluster_id/q_value/hop_count   record words 0..3
//   address, wr_en, mem_data_in   memory write port (registered)
//   mem_data_out                  memory read data, 1-cycle latency
//   busy, done                    handshake status
//   range_err, verify_err         error flags, valid until next start
module qtable_writer
    import qtable_writer_pkg::*;
#(
    parameter logic [15:0] TABLE_BASE    = 16'h0100,
    parameter int          MAX_NEIGHBORS = 32,
    parameter int          RECORD_BYTES  = 8
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  nbr_index,
    input  logic [15:0] node_id,
    input  logic [15:0] cluster_id,
    input  logic [15:0] q_value,
    input  logic [15:0] hop_count,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        busy,
    output logic        done,
    output logic        range_err,
    output logic        verify_err
);

    state_t                state;
    logic [2:0]            k;          // word counter; VERIFY runs it to 5
    logic [7:0]            slot_q;
    logic [WORD_WIDTH-1:0] words_q [WORDS_PER_RECORD];
    logic [WORD_WIDTH-1:0] word_addr;
    logic                  in_range;
    logic                  verify_err_q;

    assign in_range = 32'(nbr_index) < MAX_NEIGHBORS;

    qtable_addr_gen #(
        .TABLE_BASE  (TABLE_BASE),
        .RECORD_BYTES(RECORD_BYTES)
    ) u_addr_gen (
        .slot(slot_q),
        .word(k[1:0]),
        .addr(word_addr)
    );

`ifdef QW_READBACK_EN
    localparam state_t AFTER_WRITE = S_VERIFY;

    // Compare at k = 2..5 checks the word whose read was issued two edges earlier.
    logic [1:0] cmp_idx;
    assign cmp_idx    = 2'(k - 3'd2);
    assign verify_err = verify_err_q;
`else
    localparam state_t AFTER_WRITE = S_DONE;

    logic unused_rd;
    assign unused_rd  = ^{mem_data_out, verify_err_q};
    assign verify_err = 1'b0;
`endif

    // NOTE: the record buffer is pure datapath, loaded only on an accepted
    // start before it is ever read, so it carries no reset.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            slot_q             <= nbr_index;
            words_q[W_NODE]    <= node_id;
            words_q[W_CLUSTER] <= cluster_id;
            words_q[W_QVAL]    <= q_value;
            words_q[W_HOP]     <= hop_count;
        end
    end

    // NOTE: all FSM state and outputs use non-blocking assignments so every
    // branch sees the pre-edge values of k, done and state.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            k            <= '0;
            address      <= '0;
            wr_en        <= 1'b0;
            mem_data_in  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            range_err    <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    address <= '0;
                    wr_en   <= 1'b0;
                    if (start) begin
                        busy         <= 1'b1;
                        range_err    <= !in_range;
                        verify_err_q <= 1'b0;
                        k            <= '0;
                        state        <= in_range ? S_WRITE : S_DONE;
                    end
                end

                S_WRITE: begin
                    address     <= word_addr;
                    wr_en       <= 1'b1;
                    mem_data_in <= words_q[k[1:0]];
                    if (k == 3'd3) begin
                        k     <= '0;
                        state <= AFTER_WRITE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end

`ifdef QW_READBACK_EN
                S_VERIFY: begin
                    wr_en <= 1'b0;
                    if (!k[2])
                        address <= word_addr;
                    if (k >= 3'd2 && mem_data_out != words_q[cmp_idx])
                        verify_err_q <= 1'b1;
                    if (k == 3'd5) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
`endif

                S_DONE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    // Leave only once done has been visible for at least one
                    // cycle, so the requester always sees completion.
                    if (done && !start) begin
                        done    <= 1'b0;
                        address <= '0;
                        state   <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
